sram_buffer: RTL and testbench

Responder side of the controller's weight/input/output fetch handshake. Accepts single-cycle `get_weights`, `get_inputs` and `get_out` requests from the controller and turns each into one SRAM access. Reads are returned as a 64-bit word with a one-cycle `data_ready` pulse; writes are acknowledged with a one-cycle `out_done` pulse. Sits between the controller and the on-chip SRAM macro; its base addresses come from AHB configuration registers.

---
 rtl/sram_buffer_pkg.sv | 34 +++
 rtl/buf_latency_cnt.sv | 45 ++++
 rtl/sram_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_sram_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_buffer_pkg
// Description : Shared types and constants for the SRAM fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_buffer_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_READ_WAIT  = 3'd2,
        ST_RESP       = 3'd3,
        ST_WRITE      = 3'd4,
        ST_WRITE_WAIT = 3'd5,
        ST_DONE       = 3'd6
    } buf_state_t;

    typedef enum logic [1:0] {
        REQ_W = 2'd0,
        REQ_I = 2'd1,
        REQ_O = 2'd2
    } req_t;

    // The strobe and response states each take one cycle, so the wait
    // state covers the remaining LATENCY-1 cycles (counter runs to zero).
    function automatic int wait_load(input int latency);
        return (latency >= 2) ? (latency - 2) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/buf_latency_cnt.sv
`default_nettype none
// ============================================================================
// Module      : buf_latency_cnt
// Description : Loadable down-counter timing the SRAM access latency.
// Revision    : 1.0 - initial release
// ============================================================================
module buf_latency_cnt #(
    parameter int W        = 4,
    parameter int LOAD_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic zero
);

    localparam logic [W-1:0] C_LOAD = W'(LOAD_VAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = C_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sram_buffer
// Description : Turns controller weight/input/output requests into SRAM
//               accesses with registered read data and completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_buffer
    import sram_buffer_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] weight_base,
    input  logic [ADDR_W-1:0] input_base,
    input  logic [ADDR_W-1:0] output_base,
    input  logic              get_weights,
    input  logic              get_inputs,
    input  logic              get_out,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] data,
    output logic              data_ready,
    output logic              out_done,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int C_CNT_W     = $clog2(LATENCY + 1);
    localparam int C_WAIT_LOAD = wait_load(LATENCY);

    buf_state_t        state_q, state_d;
    req_t              req_q, req_d;

    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] i_ptr_q, i_ptr_d;
    logic [ADDR_W-1:0] o_ptr_q, o_ptr_d;

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              data_ready_q, data_ready_d;
    logic              out_done_q, out_done_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;

    logic              w_any_req;
    logic              w_cnt_load;
    logic              w_cnt_zero;

    assign w_any_req  = get_weights | get_inputs | get_out;
    assign w_cnt_load = (state_q == ST_READ) || (state_q == ST_WRITE);

    buf_latency_cnt #(
        .W        (C_CNT_W),
        .LOAD_VAL (C_WAIT_LOAD)
    ) u_lat_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (w_cnt_load),
        .clear (start),
        .zero  (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= REQ_W;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        if (start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (get_out) begin
                        state_d = ST_WRITE;
                        req_d   = REQ_O;
                    end else if (get_weights) begin
                        state_d = ST_READ;
                        req_d   = REQ_W;
                    end else if (get_inputs) begin
                        state_d = ST_READ;
                        req_d   = REQ_I;
                    end
                end
                ST_READ:       state_d = (LATENCY == 1) ? ST_RESP : ST_READ_WAIT;
                ST_READ_WAIT:  if (w_cnt_zero) state_d = ST_RESP;
                ST_RESP:       state_d = ST_IDLE;
                ST_WRITE:      state_d = (LATENCY == 1) ? ST_DONE : ST_WRITE_WAIT;
                ST_WRITE_WAIT: if (w_cnt_zero) state_d = ST_DONE;
                ST_DONE:       state_d = ST_IDLE;
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        data_d       = data_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        data_ready_d = 1'b0;
        out_done_d   = 1'b0;
        ren_d        = 1'b0;
        wen_d        = 1'b0;
        busy_d       = (state_q != ST_IDLE);
        err_d        = err_q;
        w_ptr_d      = w_ptr_q;
        i_ptr_d      = i_ptr_q;
        o_ptr_d      = o_ptr_q;

        if (start) begin
            // Abort: nothing completes, and same-cycle requests are not errors.
            busy_d  = 1'b0;
            err_d   = 1'b0;
            w_ptr_d = '0;
            i_ptr_d = '0;
            o_ptr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (get_out) begin
                        wen_d   = 1'b1;
                        addr_d  = output_base + o_ptr_q;
                        wdata_d = out_data;
                        err_d   = err_q | get_weights | get_inputs;
                    end else if (get_weights) begin
                        ren_d  = 1'b1;
                        addr_d = weight_base + w_ptr_q;
                        err_d  = err_q | get_inputs;
                    end else if (get_inputs) begin
                        ren_d  = 1'b1;
                        addr_d = input_base + i_ptr_q;
                    end
                end
                ST_RESP: begin
                    data_d       = sram_rdata;
                    data_ready_d = 1'b1;
                    if (req_q == REQ_W) begin
                        w_ptr_d = w_ptr_q + 1'b1;
                    end else begin
                        i_ptr_d = i_ptr_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    out_done_d = 1'b1;
                    o_ptr_d    = o_ptr_q + 1'b1;
                end
                default: ;
            endcase

            if ((state_q != ST_IDLE) && w_any_req) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            wdata_q      <= '0;
            addr_q       <= '0;
            data_ready_q <= 1'b0;
            out_done_q   <= 1'b0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            w_ptr_q      <= '0;
            i_ptr_q      <= '0;
            o_ptr_q      <= '0;
        end else begin
            data_q       <= data_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            data_ready_q <= data_ready_d;
            out_done_q   <= out_done_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            w_ptr_q      <= w_ptr_d;
            i_ptr_q      <= i_ptr_d;
            o_ptr_q      <= o_ptr_d;
        end
    end

    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign out_done   = out_done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign sram_addr  = addr_q;
    assign sram_ren   = ren_q;
    assign sram_wen   = wen_q;
    assign sram_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_buffer
// Description : Directed scoreboard bench for sram_buffer with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_buffer;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] weight_base = '0;
    logic [ADDR_W-1:0] input_base = '0;
    logic [ADDR_W-1:0] output_base = '0;
    logic              get_weights = 1'b0;
    logic              get_inputs = 1'b0;
    logic              get_out = 1'b0;
    logic [63:0]       out_data = '0;
    logic [63:0]       data;
    logic              data_ready;
    logic              out_done;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ren;
    logic              sram_wen;
    logic [63:0]       sram_wdata;
    logic [63:0]       sram_rdata;

    always #5 clk = ~clk;

    sram_buffer #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .weight_base (weight_base),
        .input_base  (input_base),
        .output_base (output_base),
        .get_weights (get_weights),
        .get_inputs  (get_inputs),
        .get_out     (get_out),
        .out_data    (out_data),
        .data        (data),
        .data_ready  (data_ready),
        .out_done    (out_done),
        .busy        (busy),
        .err         (err),
        .sram_addr   (sram_addr),
        .sram_ren    (sram_ren),
        .sram_wen    (sram_wen),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [63:0] wd;
    } acc_t;

    acc_t        exp_acc[$];
    logic [63:0] exp_rd[$];
    int          exp_done = 0;
    acc_t        mon_e;

    function automatic logic [63:0] word(input logic [9:0] a);
        return 64'hAAAA0000_BBBB0000 + {54'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // SRAM model: word delivered exactly LATENCY cycles after the strobe cycle
    logic [63:0] pipe_d [LATENCY];
    bit          pipe_v [LATENCY];

    always @(posedge clk) begin
        pipe_v[0] <= sram_ren;
        pipe_d[0] <= word(sram_addr);
        for (int k = 1; k < LATENCY; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
    end

    assign sram_rdata = pipe_v[LATENCY-1] ? pipe_d[LATENCY-1] : 64'h5A5A_5A5A_5A5A_5A5A;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_ren || sram_wen) begin
                chk("strobe_exclusive", 64'(sram_ren & sram_wen), 64'd0);
                chk("access_expected", 64'(exp_acc.size() > 0), 64'd1);
                if (exp_acc.size() > 0) begin
                    mon_e = exp_acc.pop_front();
                    chk("access_kind", 64'(sram_wen), 64'(mon_e.wr));
                    chk("access_addr", 64'(sram_addr), 64'(mon_e.addr));
                    if (mon_e.wr) chk("write_data", sram_wdata, mon_e.wd);
                end
            end
            if (data_ready) begin
                chk("data_ready_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) chk("read_data", data, exp_rd.pop_front());
            end
            if (out_done) begin
                chk("out_done_expected", 64'(exp_done > 0), 64'd1);
                if (exp_done > 0) exp_done--;
            end
        end
    end

    task automatic issue(input bit w, input bit i, input bit o, input logic [63:0] od);
        get_weights = w;
        get_inputs  = i;
        get_out     = o;
        out_data    = od;
        @(negedge clk);
        get_weights = 1'b0;
        get_inputs  = 1'b0;
        get_out     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit wr, input int lat0);
        int lat = lat0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (wr ? out_done : data_ready) break;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(LATENCY + 1));
    endtask

    task automatic do_txn(input bit w, input bit i, input bit o,
                          input logic [9:0] a, input logic [63:0] d, input string tag);
        if (o) begin
            exp_acc.push_back('{1'b1, a, d});
            exp_done++;
        end else begin
            exp_acc.push_back('{1'b0, a, 64'd0});
            exp_rd.push_back(word(a));
        end
        issue(w, i, o, d);
        wait_done(tag, o, 0);
    endtask

    initial begin
        logic [9:0] a;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", data, 64'd0);
        chk("reset_flags", 64'({data_ready, out_done, busy, err, sram_ren, sram_wen}), 64'd0);
        chk("reset_addr", 64'(sram_addr), 64'd0);
        chk("reset_wdata", sram_wdata, 64'd0);

        weight_base = 10'h100;
        input_base  = 10'h200;
        output_base = 10'h300;

        for (int k = 0; k < 8; k++) begin
            a = 10'h100 + 10'(k);
            do_txn(1'b1, 1'b0, 1'b0, a, 64'd0, "weight_stream");
            repeat (2) @(negedge clk);
        end
        chk("stream_err", 64'(err), 64'd0);
        chk("stream_data_held", data, word(10'h107));

        do_txn(1'b0, 1'b1, 1'b0, 10'h200, 64'd0, "inter_in0");
        @(negedge clk);
        do_txn(1'b0, 1'b0, 1'b1, 10'h300, 64'hDEADBEEF_00000001, "inter_out");
        @(negedge clk);
        chk("data_held_after_write", data, word(10'h200));
        do_txn(1'b0, 1'b1, 1'b0, 10'h201, 64'd0, "inter_in1");
        @(negedge clk);
        chk("inter_err", 64'(err), 64'd0);

        // get_out wins over get_weights; the dropped weight request flags err
        do_txn(1'b1, 1'b0, 1'b1, 10'h301, 64'h0123_4567_89AB_CDEF, "prio_out");
        @(negedge clk);
        chk("prio_err", 64'(err), 64'd1);

        exp_acc.push_back('{1'b0, 10'h108, 64'd0});
        exp_rd.push_back(word(10'h108));
        issue(1'b1, 1'b0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        issue(1'b0, 1'b1, 1'b0, 64'd0);
        wait_done("collide_rd", 1'b0, 4);
        @(negedge clk);
        chk("collide_err", 64'(err), 64'd1);
        do_txn(1'b1, 1'b0, 1'b0, 10'h109, 64'd0, "collide_next_w");
        do_txn(1'b0, 1'b1, 1'b0, 10'h202, 64'd0, "collide_next_i");
        @(negedge clk);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears_err", 64'(err), 64'd0);

        start = 1'b1;
        get_weights = 1'b1;
        @(negedge clk);
        start = 1'b0;
        get_weights = 1'b0;
        repeat (LATENCY + 3) @(negedge clk);
        chk("start_req_err", 64'(err), 64'd0);
        chk("start_req_busy", 64'(busy), 64'd0);

        weight_base = 10'h3FE;
        do_txn(1'b1, 1'b0, 1'b0, 10'h3FE, 64'd0, "wrap0");
        do_txn(1'b1, 1'b0, 1'b0, 10'h3FF, 64'd0, "wrap1");
        do_txn(1'b1, 1'b0, 1'b0, 10'h000, 64'd0, "wrap2");
        @(negedge clk);

        exp_acc.push_back('{1'b0, 10'h001, 64'd0});
        issue(1'b1, 1'b0, 1'b0, 64'd0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (LATENCY + 4) @(negedge clk);
        chk("abort_data_held", data, word(10'h000));
        do_txn(1'b1, 1'b0, 1'b0, 10'h3FE, 64'd0, "abort_restart");
        @(negedge clk);

        exp_acc.push_back('{1'b1, 10'h300, 64'hCAFE_F00D_1234_5678});
        issue(1'b0, 1'b0, 1'b1, 64'hCAFE_F00D_1234_5678);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_flags", 64'({busy, out_done, data_ready, err, sram_ren, sram_wen}), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_wdata", sram_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LATENCY + 6) @(negedge clk);

        chk("acc_queue_drained", 64'(exp_acc.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("done_pending", 64'(exp_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
